frv_gpr_wb: RTL and testbench

Writeback arbiter and scoreboard sitting directly upstream of the general purpose register file. It merges register write requests from the execute path and the load/store unit into the single GPR write port, registering the winning write for one cycle. It also tracks long-latency destination registers (pending loads) in a 32-entry scoreboard so decode can stall on RAW/WAW hazards.

---
 rtl/frv_gpr_wb.sv | 101 ++++++++++
 tb/tb_frv_gpr_wb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frv_gpr_wb.sv
// frv_gpr_wb: GPR writeback arbiter plus pending-load scoreboard.
// Merges EX and LSU writes onto one registered GPR write port.
module frv_gpr_wb #(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_addr,
  input  logic [4:0]      rs1_addr,
  output logic            rs1_busy,
  input  logic [4:0]      rs2_addr,
  output logic            rs2_busy,
  output logic            sb_any,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata
);

  // r_last = 1 means LSU won the last contested cycle
  logic            r_last;
  logic            r_rd_wen;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_wdata;
  logic            r_from_lsu;
  logic [31:0]     r_pend;

  logic            w_both;
  logic            w_ex_gnt;
  logic            w_lsu_gnt;
  logic            w_gnt;
  logic [4:0]      w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  logic [31:0]     w_pend_nxt;

  // Round-robin grant; nothing is accepted while in reset
  always_comb begin
    w_both    = ex_valid & lsu_valid;
    w_ex_gnt  = g_resetn & ex_valid & (~lsu_valid | r_last);
    w_lsu_gnt = g_resetn & lsu_valid & (~ex_valid | ~r_last);
    w_gnt     = w_ex_gnt | w_lsu_gnt;
    w_addr    = w_lsu_gnt ? lsu_addr : ex_addr;
    w_wdata   = w_lsu_gnt ? lsu_wdata : ex_wdata;
  end

  // Scoreboard next state: set beats clear, bit 0 never pending
  always_comb begin
    w_set = 32'd0;
    w_clr = 32'd0;
    if (rsv_valid && rsv_addr != 5'd0)
      w_set = 32'd1 << rsv_addr;
    if (r_rd_wen && r_from_lsu)
      w_clr = 32'd1 << r_rd_addr;
    w_pend_nxt = ((r_pend & ~w_clr) | w_set) & ~32'd1;
  end

  // Output stage, arbitration history and scoreboard state
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_last     <= 1'b0;
      r_rd_wen   <= 1'b0;
      r_rd_addr  <= 5'd0;
      r_rd_wdata <= '0;
      r_from_lsu <= 1'b0;
      r_pend     <= 32'd0;
    end else begin
      r_rd_wen   <= w_gnt & (w_addr != 5'd0);
      r_from_lsu <= w_lsu_gnt;
      if (w_gnt) begin
        r_rd_addr  <= w_addr;
        r_rd_wdata <= w_wdata;
      end
      if (w_both)
        r_last <= w_lsu_gnt;
      r_pend <= w_pend_nxt;
    end
  end

  // Combinational hazard lookup and port drive
  always_comb begin
    rs1_busy  = r_pend[rs1_addr];
    rs2_busy  = r_pend[rs2_addr];
    sb_any    = |r_pend;
    ex_ready  = w_ex_gnt;
    lsu_ready = w_lsu_gnt;
    rd_wen    = r_rd_wen;
    rd_addr   = r_rd_addr;
    rd_wdata  = r_rd_wdata;
  end

endmodule

// File: tb/tb_frv_gpr_wb.sv
// tb_frv_gpr_wb: directed plus random checks of frv_gpr_wb
// against a cycle-level behavioural model.
module tb_frv_gpr_wb;

  logic        g_clk;
  logic        g_resetn;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  rs1_addr;
  logic        rs1_busy;
  logic [4:0]  rs2_addr;
  logic        rs2_busy;
  logic        sb_any;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_wdata;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;

  frv_gpr_wb #(.XLEN(32)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_busy(rs2_busy),
    .sb_any(sb_any),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit          m_pend [32];
  bit          m_lsu_turn;
  bit          m_wen;
  bit          m_from_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          g_ex;
  bit          g_lsu;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_lsu_turn = 1'b1;
    m_wen      = 1'b0;
    m_from_lsu = 1'b0;
    m_addr     = 5'd0;
    m_data     = 32'd0;
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    foreach (m_pend[i]) a |= m_pend[i];
    return a;
  endfunction

  // check one cycle against the model, then advance both by one edge
  task automatic cyc();
    bit ge, gl, b1, b2;
    #1;
    if (!g_resetn) begin
      ge = 0; gl = 0;
    end else if (ex_valid && lsu_valid) begin
      gl = m_lsu_turn; ge = !gl;
    end else begin
      ge = ex_valid; gl = lsu_valid;
    end
    b1 = (rs1_addr == 0) ? 1'b0 : m_pend[rs1_addr];
    b2 = (rs2_addr == 0) ? 1'b0 : m_pend[rs2_addr];
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, ge});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, gl});
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, b1});
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, b2});
    chk("sb_any", {31'd0, sb_any}, {31'd0, any_pend()});
    chk("rd_wen", {31'd0, rd_wen}, {31'd0, m_wen});
    chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
    chk("rd_wdata", rd_wdata, m_data);
    g_ex = ge; g_lsu = gl;
    if (!g_resetn) begin
      model_reset();
    end else begin
      if (m_wen && m_from_lsu) m_pend[m_addr] = 1'b0;
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (ge || gl) begin
        m_addr = gl ? lsu_addr : ex_addr;
        m_data = gl ? lsu_wdata : ex_wdata;
      end
      m_wen      = (ge || gl) && ((gl ? lsu_addr : ex_addr) != 0);
      m_from_lsu = gl;
      if (ex_valid && lsu_valid) m_lsu_turn = ge;
    end
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  task automatic idle();
    rsv_valid = 0; rsv_addr = 0;
    ex_valid = 0; ex_addr = 0; ex_wdata = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_wdata = 0;
  endtask

  initial begin
    idle();
    rs1_addr = 0; rs2_addr = 0;
    g_resetn = 0;
    ex_valid = 1; lsu_valid = 1;
    ex_addr = 3; lsu_addr = 4;
    model_reset();
    @(posedge g_clk);
    @(negedge g_clk);
    // reset held with both requesters valid
    cyc();
    cyc();
    chk("rst_rd_wen", {31'd0, rd_wen}, 32'd0);
    chk("rst_rd_wdata", rd_wdata, 32'd0);
    g_resetn = 1;
    idle();
    cyc();

    // single EX write
    ex_valid = 1; ex_addr = 5; ex_wdata = 32'hDEADBEEF;
    cyc();
    idle();
    chk("ex_rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("ex_rd_wdata", rd_wdata, 32'hDEADBEEF);
    cyc();
    chk("ex_rd_wen_off", {31'd0, rd_wen}, 32'd0);

    // load scoreboard on x7
    rsv_valid = 1; rsv_addr = 7; rs1_addr = 7;
    cyc();
    idle();
    chk("sb7_busy", {31'd0, rs1_busy}, 32'd1);
    cyc();
    lsu_valid = 1; lsu_addr = 7; lsu_wdata = 32'h12345678;
    cyc();
    idle();
    chk("sb7_busy_m1", {31'd0, rs1_busy}, 32'd1);
    cyc();
    chk("sb7_busy_m2", {31'd0, rs1_busy}, 32'd0);
    chk("sb7_any_m2", {31'd0, sb_any}, 32'd0);
    cyc();

    // contention: LSU, EX, LSU, EX
    ex_valid = 1; ex_addr = 1; ex_wdata = 32'h11;
    lsu_valid = 1; lsu_addr = 2; lsu_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_rd_addr", {27'd0, rd_addr}, (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    idle();
    cyc();

    // x0 handling
    rsv_valid = 1; rsv_addr = 0; rs1_addr = 0;
    cyc();
    idle();
    lsu_valid = 1; lsu_addr = 0; lsu_wdata = 32'hAAAA5555;
    cyc();
    idle();
    chk("x0_wen", {31'd0, rd_wen}, 32'd0);
    chk("x0_any", {31'd0, sb_any}, 32'd0);
    cyc();

    // set/clear collision on x9, EX write to pending x9
    rsv_valid = 1; rsv_addr = 9; rs1_addr = 9;
    cyc();
    idle();
    lsu_valid = 1; lsu_addr = 9; lsu_wdata = 32'h99;
    cyc();
    idle();
    rsv_valid = 1; rsv_addr = 9;
    ex_valid = 1; ex_addr = 9; ex_wdata = 32'h909;
    cyc();
    idle();
    chk("col_busy", {31'd0, rs1_busy}, 32'd1);
    chk("col_ex_wen", {31'd0, rd_wen}, 32'd1);
    cyc();
    chk("col_busy2", {31'd0, rs1_busy}, 32'd1);

    // randomized traffic; losers hold their request until accepted
    for (int n = 0; n < 400; n++) begin
      g_resetn = (n == 200) ? 1'b0 : 1'b1;
      if (!(ex_valid && !g_ex)) begin
        ex_valid = ($urandom % 3) != 0;
        ex_addr  = 5'($urandom_range(0, 7));
        ex_wdata = $urandom;
      end
      if (!(lsu_valid && !g_lsu)) begin
        lsu_valid = ($urandom % 3) == 0;
        lsu_addr  = 5'($urandom_range(0, 7));
        lsu_wdata = $urandom;
      end
      rsv_valid = ($urandom % 4) == 0;
      rsv_addr  = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
